edge_event_arbiter: RTL and testbench
=====================================

Name: edge_event_arbiter

Overview:
- Collects rising-edge events from N_CH asynchronous inputs, holds them as pending requests, and offers them one at a time to a single consumer over a valid/ready handshake.
- Grant order is round-robin.
- Sits between raw external strobes (buttons, sensor flags) and the control logic that services them.
- Provides per-channel enable, pending visibility, and sticky overflow flags.

Parameters:
- N_CH, 4: number of event channels (2..32).
- SYNC_STAGES, 2: synchronizer flops per channel (>=2).
- ID_W, $clog2(N_CH): width of the channel index.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- async_i  in  N_CH  raw asynchronous event inputs.
- en_i  in  N_CH  per-channel enable; a disabled channel ignores rises and drops its pending flag.
- ovf_clr_i  in  N_CH  per-channel clear for the overflow flags.
- event_valid_o  out  1  an event is offered.
- event_id_o  out  ID_W  channel index of the offered event.
- event_ready_i  in  1  consumer accepts the offered event.
- pending_o  out  N_CH  pending flags, not including the channel currently offered.
- overflow_o  out  N_CH  sticky flag: a rise arrived while that channel was already pending.

Behaviour:
- Reset values (clk edge with reset=1):
  - Sync chains, previous-value flops, pending_o, overflow_o: all 0.
  - event_valid_o=0, event_id_o=0, FSM=IDLE, rr_ptr=N_CH-1 (channel 0 has first priority).
- Per channel, synchronize async_i through SYNC_STAGES flops to get sync. Then rise = sync & ~prev, where prev is sync delayed one cycle.
- An input held high through reset release produces one rise after reset. This is intended.
- Pending set/clear:
  - pending[k] sets on a clk edge when rise[k] & en_i[k].
  - pending[k] clears when channel k is loaded into the offer register.
  - pending[k] also clears when en_i[k]=0 and no rise/set applies.
  - Set takes priority over load-clear in the same cycle.
- Overflow:
  - overflow[k] sets when rise[k] & en_i[k] & pending[k].
  - It clears on ovf_clr_i[k]; set wins over a simultaneous clear.
  - Overflow is independent of the offered event, so a rise during an offer of channel k is not an overflow.
- Latency: an async_i edge before clk edge 0 gives sync=1 after edge SYNC_STAGES. pending[k]=1 after edge SYNC_STAGES+1. event_valid_o=1 after edge SYNC_STAGES+2, which is 4 cycles at the default.
- Arbitration: search pending starting at rr_ptr+1, modulo N_CH, taking the first set bit. On load, rr_ptr takes the granted index.
- FSM:
  - IDLE: if any pending, load the winner into event_id_o, set event_valid_o, clear that pending bit, go to OFFER. Otherwise stay.
  - OFFER: event_valid_o and event_id_o are held stable until event_ready_i=1.
    - On a handshake with any pending: load the next winner at the same edge and stay in OFFER. This gives back-to-back transfers at 1 event/clk.
    - On a handshake with nothing pending: event_valid_o=0, go to IDLE.
- Disabling the offered channel does not withdraw the offer; it completes normally.
- event_ready_i is ignored when event_valid_o=0.
- The arbiter uses pending values registered before the edge. An event rising in the same cycle as a handshake is eligible one cycle later.
- Reset asserted mid-offer: everything returns to reset values at that edge, and pending and offered events are discarded.
- Outputs are registered; there is no combinational path from event_ready_i to any output.

Decomposition:
- Package edge_event_pkg holds:
  - typedef enum logic {IDLE, OFFER} arb_state_t;
  - localparam MIN_SYNC_STAGES = 2;
  - the round-robin search function rr_pick(pending, ptr) returning {found, id}.
- Sub-module sync_rise_det: one channel's synchronizer chain plus previous-value flop, with output rise. It has parameter SYNC_STAGES and ports clk/reset, and is instantiated N_CH times in a generate loop.
- The FSM, pending, overflow and pointer logic stay in edge_event_arbiter.

Test Plan:
- Single event: en_i=4'hF, ready=1, pulse async_i[2] high for 3 cycles → event_valid_o=1 with id=2 for exactly one cycle, 4 cycles after the edge. pending_o and overflow_o remain 0.
- Round-robin fairness: ready=0, raise channels 0, 1 and 3 together, then hold ready=1 → ids 0,1,3 appear on consecutive cycles, valid drops after id 3, and rr_ptr=3. Re-raise channels 0 and 3 → order is 0 then 3.
- Backpressure stability: an offer of id=1 with ready=0 for 10 cycles, while channel 1 rises again → event_valid_o and id stay constant, pending_o[1]=1, overflow_o[1]=0. After ready, id=1 is offered again.
- Overflow: ready=0, offer channel 0 busy, then two separate rises on channel 2 → overflow_o[2]=1 and sticky. Assert ovf_clr_i[2] in the same cycle as a third rise → overflow stays 1. A later clear alone → 0.
- Enable masking: en_i[3]=0 while async_i[3] pulses → no pending and no offer. With pending[3]=1, drop en_i[3] → pending_o[3]=0 next cycle and no event.
- Reset mid-offer: offer valid with two pending, then assert reset one cycle → all outputs 0. With async_i held high through reset release, each high channel produces exactly one event.

Source files
------------

// File: rtl/edge_event_pkg.sv
// Shared types and helpers for the edge event arbiter.
// Holds the FSM state type and the round-robin search.
package edge_event_pkg;

    typedef enum logic {IDLE, OFFER} arb_state_t;

    localparam int MIN_SYNC_STAGES = 2;

    // Returns {found, id}; the search starts just after ptr and wraps at n.
    function automatic logic [5:0] rr_pick(
        input logic [31:0] pending,
        input logic [4:0]  ptr,
        input int unsigned n
    );
        logic        found;
        logic [4:0]  id;
        int unsigned idx;
        found = 1'b0;
        id    = '0;
        idx   = 0;
        for (int unsigned i = 1; i <= 32; i++) begin
            if (i <= n && !found) begin
                idx = (int'(ptr) + i) % n;
                if (pending[idx]) begin
                    found = 1'b1;
                    id    = idx[4:0];
                end
            end
        end
        return {found, id};
    endfunction

endpackage

// File: rtl/edge_event_arbiter_sync_rise_det.sv
// One channel: synchronizer chain plus previous-value flop.
// Emits a one-cycle rise when the synchronized level goes 0 -> 1.
module sync_rise_det
    import edge_event_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic rise_o
);

    localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ?
                            MIN_SYNC_STAGES : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector with round-robin valid/ready offer.
// Pending, overflow, pointer and offer FSM live here.
module edge_event_arbiter
    import edge_event_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] async_i,
    input  logic [N_CH-1:0] en_i,
    input  logic [N_CH-1:0] ovf_clr_i,
    output logic            event_valid_o,
    output logic [ID_W-1:0] event_id_o,
    input  logic            event_ready_i,
    output logic [N_CH-1:0] pending_o,
    output logic [N_CH-1:0] overflow_o
);

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] ovf_q, ovf_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] rr_q, rr_d;
    arb_state_t      state_q, state_d;
    logic [5:0]      pick;
    logic            found;
    logic [ID_W-1:0] win;
    logic            load;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        sync_rise_det #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_det (
            .clk    (clk),
            .reset  (reset),
            .async_i(async_i[k]),
            .rise_o (rise[k])
        );
    end

    assign pick  = rr_pick(32'(pending_q), 5'(rr_q), N_CH);
    assign found = pick[5];
    assign win   = ID_W'(pick[4:0]);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rr_d    = rr_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    load    = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (event_ready_i) begin
                    if (found) load = 1'b1;
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            id_d = win;
            rr_d = win;
        end
    end

    // A fresh rise outranks both the disable-drop and the load-clear.
    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_q;
        for (int k = 0; k < N_CH; k++) begin
            if (rise[k] && en_i[k]) begin
                pending_d[k] = 1'b1;
            end else if (!en_i[k]) begin
                pending_d[k] = 1'b0;
            end else if (load && (win == ID_W'(k))) begin
                pending_d[k] = 1'b0;
            end
            if (rise[k] && en_i[k] && pending_q[k]) begin
                ovf_d[k] = 1'b1;
            end else if (ovf_clr_i[k]) begin
                ovf_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            id_q      <= '0;
            rr_q      <= ID_W'(N_CH - 1);
            pending_q <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            rr_q      <= rr_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign event_valid_o = (state_q == OFFER);
    assign event_id_o    = id_q;
    assign pending_o     = pending_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized bench for edge_event_arbiter with a reference model.
// Expected outputs are queued per cycle and checked by a monitor.
module tb_edge_event_arbiter;

    localparam int N = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] async_i;
    logic [N-1:0] en_i;
    logic [N-1:0] ovf_clr_i;
    logic         event_valid_o;
    logic [1:0]   event_id_o;
    logic         event_ready_i;
    logic [N-1:0] pending_o;
    logic [N-1:0] overflow_o;

    edge_event_arbiter #(.N_CH(N), .SYNC_STAGES(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .async_i      (async_i),
        .en_i         (en_i),
        .ovf_clr_i    (ovf_clr_i),
        .event_valid_o(event_valid_o),
        .event_id_o   (event_id_o),
        .event_ready_i(event_ready_i),
        .pending_o    (pending_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         v;
        logic [1:0]   id;
        logic [N-1:0] pend;
        logic [N-1:0] ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   events = 0;

    // Model state: sampled async history (index 0 = most recent edge).
    logic [N-1:0] hist[$];
    logic [N-1:0] m_pend, m_ovf;
    logic         m_v;
    int           m_id, m_rr;

    function automatic int find_next(logic [N-1:0] p, int ptr);
        for (int i = 1; i <= N; i++) begin
            if (p[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back('0);
        m_pend = '0;
        m_ovf  = '0;
        m_v    = 1'b0;
        m_id   = 0;
        m_rr   = N - 1;
    endtask

    // Advance the model by one clock edge using the inputs just sampled.
    task automatic model_edge();
        logic [N-1:0] rise, np, no;
        logic         hs, ld;
        int           w;
        exp_t         e;
        if (reset) begin
            model_reset();
        end else begin
            rise = hist[S-1] & ~hist[S];
            hs   = m_v & event_ready_i;
            w    = find_next(m_pend, m_rr);
            ld   = (!m_v || hs) && (w >= 0);
            if (hs) events++;
            for (int k = 0; k < N; k++) begin
                if (rise[k] && en_i[k]) np[k] = 1'b1;
                else if (!en_i[k]) np[k] = 1'b0;
                else if (ld && w == k) np[k] = 1'b0;
                else np[k] = m_pend[k];
                if (rise[k] && en_i[k] && m_pend[k]) no[k] = 1'b1;
                else if (ovf_clr_i[k]) no[k] = 1'b0;
                else no[k] = m_ovf[k];
            end
            if (ld) begin
                m_v  = 1'b1;
                m_id = w;
                m_rr = w;
            end else if (hs) begin
                m_v = 1'b0;
            end
            m_pend = np;
            m_ovf  = no;
            hist.push_front(async_i);
            void'(hist.pop_back());
        end
        e.v    = m_v;
        e.id   = 2'(m_id);
        e.pend = m_pend;
        e.ovf  = m_ovf;
        q.push_back(e);
    endtask

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic pulse(logic [N-1:0] m, int hi, int lo);
        async_i = async_i | m;
        cyc(hi);
        async_i = async_i & ~m;
        cyc(lo);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("valid", 32'(event_valid_o), 32'(e.v));
                chk("id", 32'(event_id_o), 32'(e.id));
                chk("pending", 32'(pending_o), 32'(e.pend));
                chk("overflow", 32'(overflow_o), 32'(e.ovf));
            end
        end
    end

    initial begin : driver
        model_reset();
        reset         = 1'b1;
        async_i       = '0;
        en_i          = '1;
        ovf_clr_i     = '0;
        event_ready_i = 1'b0;
        @(negedge clk);
        cyc(3);
        reset = 1'b0;
        cyc(2);

        // Single event on channel 2 with ready held high.
        event_ready_i = 1'b1;
        pulse(4'b0100, 3, 8);

        // Round-robin across 0, 1, 3 then 0, 3.
        event_ready_i = 1'b0;
        pulse(4'b1011, 3, 4);
        event_ready_i = 1'b1;
        cyc(6);
        pulse(4'b1001, 3, 8);

        // Backpressure with a second rise on the offered channel.
        event_ready_i = 1'b0;
        pulse(4'b0010, 3, 4);
        pulse(4'b0010, 3, 10);
        event_ready_i = 1'b1;
        cyc(6);

        // Overflow: park channel 0, then repeated rises on channel 2.
        event_ready_i = 1'b0;
        pulse(4'b0001, 3, 4);
        pulse(4'b0100, 3, 3);
        pulse(4'b0100, 3, 3);
        async_i = async_i | 4'b0100;
        cyc(2);
        ovf_clr_i = 4'b0100;
        cyc(1);
        ovf_clr_i = '0;
        async_i = async_i & ~4'b0100;
        cyc(4);
        ovf_clr_i = 4'b0100;
        cyc(1);
        ovf_clr_i = '0;
        event_ready_i = 1'b1;
        cyc(6);

        // Enable masking, then dropping enable on a pending channel.
        en_i = 4'b0111;
        pulse(4'b1000, 3, 6);
        en_i = 4'b1111;
        event_ready_i = 1'b0;
        pulse(4'b0001, 3, 3);
        pulse(4'b1000, 3, 3);
        en_i = 4'b0111;
        cyc(3);
        en_i = 4'b1111;
        event_ready_i = 1'b1;
        cyc(6);

        // Reset mid-offer, with inputs held high through release.
        event_ready_i = 1'b0;
        async_i = 4'b0111;
        cyc(8);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(6);
        event_ready_i = 1'b1;
        cyc(6);
        async_i = '0;
        cyc(4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 5) == 0) async_i[k] = ~async_i[k];
            end
            en_i = ($urandom_range(0, 19) == 0) ? 4'($urandom) : '1;
            ovf_clr_i = ($urandom_range(0, 9) == 0) ? 4'($urandom) : '0;
            event_ready_i = ($urandom_range(0, 9) < 6);
            reset = ($urandom_range(0, 399) == 0);
            cyc(1);
        end
        reset = 1'b0;
        async_i = '0;
        event_ready_i = 1'b1;
        cyc(10);

        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        checks++;
        if (events < 50) begin
            failures++;
            $display("FAIL handshakes: got %0d expected at least 50", events);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
